// File: rtl/backend_redirect_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : backend_redirect_arbiter_if
// Description : Redirect request / redirect result bundle between execution
//               sources, ROB and the backend redirect arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface backend_redirect_arbiter_if #(
    parameter int SRC_NUM = 4,
    parameter int ROB_W   = 6,
    parameter int FSQ_W   = 5,
    parameter int OFF_W   = 5
);
    // Execution-source redirect requests
    logic [SRC_NUM-1:0]            src_valid;
    logic [SRC_NUM-1:0][ROB_W:0]   src_rob_idx;
    logic [SRC_NUM-1:0][FSQ_W-1:0] src_fsq_idx;
    logic [SRC_NUM-1:0][OFF_W-1:0] src_fsq_off;

    // ROB-head exception redirect
    logic                          exc_valid;
    logic [ROB_W:0]                exc_rob_idx;
    logic [FSQ_W-1:0]              exc_fsq_idx;
    logic [OFF_W-1:0]              exc_fsq_off;

    // Arbitrated redirect towards FSQ / ROB
    logic                          redirect_en;
    logic [ROB_W:0]                redirect_rob_idx;
    logic [FSQ_W-1:0]              redirect_fsq_idx;
    logic [OFF_W-1:0]              redirect_fsq_off;
    logic                          redirect_is_exc;
    logic                          flush_stall;

    // Requester side
    modport master (
        output src_valid, src_rob_idx, src_fsq_idx, src_fsq_off,
        output exc_valid, exc_rob_idx, exc_fsq_idx, exc_fsq_off,
        input  redirect_en, redirect_rob_idx, redirect_fsq_idx,
        input  redirect_fsq_off, redirect_is_exc, flush_stall
    );

    // Arbiter side
    modport slave (
        input  src_valid, src_rob_idx, src_fsq_idx, src_fsq_off,
        input  exc_valid, exc_rob_idx, exc_fsq_idx, exc_fsq_off,
        output redirect_en, redirect_rob_idx, redirect_fsq_idx,
        output redirect_fsq_off, redirect_is_exc, flush_stall
    );
endinterface
`default_nettype wire

// File: rtl/backend_redirect_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : backend_redirect_arbiter
// Description : Picks the oldest redirect (exception first) among execution
//               sources, emits a registered one-cycle redirect pulse and runs
//               a counter-driven flush window that stalls the front end and
//               drops redirects already squashed by the current flush.
// Revision    : 1.0 - initial release
// ============================================================================
module backend_redirect_arbiter #(
    parameter int SRC_NUM      = 4,
    parameter int ROB_W        = 6,
    parameter int FSQ_W        = 5,
    parameter int OFF_W        = 5,
    parameter int FLUSH_CYCLES = 3
) (
    input  wire logic               clk,
    input  wire logic               rst,
    backend_redirect_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Age compare on robIdx with a wrap (direction) MSB: same direction means
    // plain index order, differing direction means the larger index is older.
    function automatic logic is_older(input logic [ROB_W:0] a,
                                      input logic [ROB_W:0] b);
        if (a[ROB_W] == b[ROB_W])
            return a[ROB_W-1:0] < b[ROB_W-1:0];
        else
            return a[ROB_W-1:0] > b[ROB_W-1:0];
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_src_any;
    logic [ROB_W:0]   w_src_rob;
    logic [FSQ_W-1:0] w_src_fsq;
    logic [OFF_W-1:0] w_src_off;

    logic             w_cand_valid;
    logic [ROB_W:0]   w_cand_rob;
    logic [FSQ_W-1:0] w_cand_fsq;
    logic [OFF_W-1:0] w_cand_off;
    logic             w_accept;

    logic             r_redirect_en;
    logic [ROB_W:0]   r_rob;
    logic [FSQ_W-1:0] r_fsq;
    logic [OFF_W-1:0] r_off;
    logic             r_is_exc;

    // Oldest valid source; a later source replaces the current pick only if
    // strictly older, so ties resolve to the lowest source index.
    always_comb begin
        w_src_any = 1'b0;
        w_src_rob = '0;
        w_src_fsq = '0;
        w_src_off = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (bus.src_valid[i] &&
                (!w_src_any || is_older(bus.src_rob_idx[i], w_src_rob))) begin
                w_src_any = 1'b1;
                w_src_rob = bus.src_rob_idx[i];
                w_src_fsq = bus.src_fsq_idx[i];
                w_src_off = bus.src_fsq_off[i];
            end
        end
    end

    // Stage-0 candidate: the ROB exception always outranks execution sources.
    always_comb begin
        w_cand_valid = bus.exc_valid | w_src_any;
        w_cand_rob   = bus.exc_valid ? bus.exc_rob_idx : w_src_rob;
        w_cand_fsq   = bus.exc_valid ? bus.exc_fsq_idx : w_src_fsq;
        w_cand_off   = bus.exc_valid ? bus.exc_fsq_off : w_src_off;
    end

    // Next state / counter and acceptance; inside the flush window only
    // exceptions or sources strictly older than the registered winner pass.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cand_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = C_CNT_LOAD;
                end
            end
            ST_FLUSH: begin
                if (bus.exc_valid || (w_src_any && is_older(w_src_rob, r_rob))) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = C_CNT_LOAD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and flush-window counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Redirect pulse and held winner info, updated only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_en <= 1'b0;
            r_rob         <= '0;
            r_fsq         <= '0;
            r_off         <= '0;
            r_is_exc      <= 1'b0;
        end else begin
            r_redirect_en <= w_accept;
            if (w_accept) begin
                r_rob    <= w_cand_rob;
                r_fsq    <= w_cand_fsq;
                r_off    <= w_cand_off;
                r_is_exc <= bus.exc_valid;
            end
        end
    end

    assign bus.redirect_en      = r_redirect_en;
    assign bus.redirect_rob_idx = r_rob;
    assign bus.redirect_fsq_idx = r_fsq;
    assign bus.redirect_fsq_off = r_off;
    assign bus.redirect_is_exc  = r_is_exc;
    assign bus.flush_stall      = (r_state == ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_backend_redirect_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_backend_redirect_arbiter
// Description : Directed self-checking bench; expected redirects are queued
//               when stimulus is driven and compared when a pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_backend_redirect_arbiter;

    localparam int SRC_NUM      = 4;
    localparam int ROB_W        = 6;
    localparam int FSQ_W        = 5;
    localparam int OFF_W        = 5;
    localparam int FLUSH_CYCLES = 3;

    typedef struct packed {
        logic [ROB_W:0]   rob;
        logic [FSQ_W-1:0] fsq;
        logic [OFF_W-1:0] off;
        logic             exc;
    } redir_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    redir_t exp_q[$];

    backend_redirect_arbiter_if #(
        .SRC_NUM(SRC_NUM), .ROB_W(ROB_W), .FSQ_W(FSQ_W), .OFF_W(OFF_W)
    ) bus ();

    backend_redirect_arbiter #(
        .SRC_NUM(SRC_NUM), .ROB_W(ROB_W), .FSQ_W(FSQ_W), .OFF_W(OFF_W),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.src_valid   = '0;
        bus.src_rob_idx = '0;
        bus.src_fsq_idx = '0;
        bus.src_fsq_off = '0;
        bus.exc_valid   = 1'b0;
        bus.exc_rob_idx = '0;
        bus.exc_fsq_idx = '0;
        bus.exc_fsq_off = '0;
    endtask

    task automatic set_src(input int i, input logic [ROB_W:0] rob,
                           input logic [FSQ_W-1:0] fsq, input logic [OFF_W-1:0] off);
        bus.src_valid[i]   = 1'b1;
        bus.src_rob_idx[i] = rob;
        bus.src_fsq_idx[i] = fsq;
        bus.src_fsq_off[i] = off;
    endtask

    task automatic set_exc(input logic [ROB_W:0] rob,
                           input logic [FSQ_W-1:0] fsq, input logic [OFF_W-1:0] off);
        bus.exc_valid   = 1'b1;
        bus.exc_rob_idx = rob;
        bus.exc_fsq_idx = fsq;
        bus.exc_fsq_off = off;
    endtask

    task automatic expect_redir(input logic [ROB_W:0] rob, input logic [FSQ_W-1:0] fsq,
                                input logic [OFF_W-1:0] off, input logic exc);
        redir_t e;
        e.rob = rob;
        e.fsq = fsq;
        e.off = off;
        e.exc = exc;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.redirect_en === 1'b1) begin
            redir_t obs;
            redir_t e;
            obs.rob = bus.redirect_rob_idx;
            obs.fsq = bus.redirect_fsq_idx;
            obs.off = bus.redirect_fsq_off;
            obs.exc = bus.redirect_is_exc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_pulse: observed 0x%0h expected none", obs);
            end else begin
                e = exp_q.pop_front();
                assert (obs === e) else begin
                    n_fail++;
                    $error("FAIL redirect_info: observed 0x%0h expected 0x%0h", obs, e);
                end
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_en",    32'(bus.redirect_en), 32'd0);
        chk("rst_stall", 32'(bus.flush_stall), 32'd0);
        chk("rst_rob",   32'(bus.redirect_rob_idx), 32'd0);
        chk("rst_fsq",   32'(bus.redirect_fsq_idx), 32'd0);
        chk("rst_off",   32'(bus.redirect_fsq_off), 32'd0);
        chk("rst_exc",   32'(bus.redirect_is_exc), 32'd0);

        // Single source: pulse at t+1, stall t+1..t+3, low at t+4
        set_src(2, 7'h05, 5'd3, 5'd7);
        expect_redir(7'h05, 5'd3, 5'd7, 1'b0);
        tick();
        clr();
        chk("single_en_t1",    32'(bus.redirect_en), 32'd1);
        chk("single_stall_t1", 32'(bus.flush_stall), 32'd1);
        tick();
        chk("single_en_t2",    32'(bus.redirect_en), 32'd0);
        chk("single_stall_t2", 32'(bus.flush_stall), 32'd1);
        tick();
        chk("single_stall_t3", 32'(bus.flush_stall), 32'd1);
        tick();
        chk("single_stall_t4", 32'(bus.flush_stall), 32'd0);
        chk("single_hold_rob", 32'(bus.redirect_rob_idx), 32'h05);

        // Wrap: 0x45 (dir 1) is younger than 0x3E (dir 0)
        set_src(0, 7'h45, 5'd1, 5'd1);
        set_src(2, 7'h3E, 5'd2, 5'd2);
        expect_redir(7'h3E, 5'd2, 5'd2, 1'b0);
        tick();
        clr();
        chk("wrap_en", 32'(bus.redirect_en), 32'd1);
        tick(); tick(); tick();
        chk("wrap_idle", 32'(bus.flush_stall), 32'd0);

        // Filtering: younger 0x12 dropped, older 0x0C accepted and extends window
        set_src(0, 7'h10, 5'd4, 5'd4);
        expect_redir(7'h10, 5'd4, 5'd4, 1'b0);
        tick();                          // t+1
        clr();
        set_src(1, 7'h12, 5'd5, 5'd5);
        tick();                          // t+2
        clr();
        chk("filter_drop_en", 32'(bus.redirect_en), 32'd0);
        set_src(3, 7'h0C, 5'd6, 5'd6);
        expect_redir(7'h0C, 5'd6, 5'd6, 1'b0);
        tick();                          // t+3
        clr();
        chk("filter_older_en", 32'(bus.redirect_en), 32'd1);
        tick(); tick();                  // t+5
        chk("filter_stall_t5", 32'(bus.flush_stall), 32'd1);
        tick();                          // t+6
        chk("filter_stall_t6", 32'(bus.flush_stall), 32'd0);

        // Exception beats an older source, and a younger exception in FLUSH is accepted
        set_exc(7'h20, 5'd9, 5'd3);
        set_src(0, 7'h01, 5'd1, 5'd1);
        expect_redir(7'h20, 5'd9, 5'd3, 1'b1);
        tick();
        clr();
        chk("exc_is_exc", 32'(bus.redirect_is_exc), 32'd1);
        set_exc(7'h30, 5'd10, 5'd10);
        expect_redir(7'h30, 5'd10, 5'd10, 1'b1);
        tick();
        clr();
        chk("exc_flush_en", 32'(bus.redirect_en), 32'd1);
        tick(); tick(); tick();
        chk("exc_idle", 32'(bus.flush_stall), 32'd0);

        // Tie on robIdx: lowest source index wins
        set_src(1, 7'h08, 5'd11, 5'd12);
        set_src(3, 7'h08, 5'd13, 5'd14);
        expect_redir(7'h08, 5'd11, 5'd12, 1'b0);
        tick();
        clr();
        chk("tie_en", 32'(bus.redirect_en), 32'd1);
        tick(); tick(); tick();

        // Reset in the second FLUSH cycle; request during reset is discarded
        set_src(0, 7'h15, 5'd1, 5'd2);
        expect_redir(7'h15, 5'd1, 5'd2, 1'b0);
        tick();                          // first FLUSH cycle
        clr();
        tick();                          // second FLUSH cycle
        rst = 1'b1;
        set_src(1, 7'h02, 5'd7, 5'd7);
        tick();
        rst = 1'b0;
        clr();
        chk("mid_rst_stall", 32'(bus.flush_stall), 32'd0);
        chk("mid_rst_en",    32'(bus.redirect_en), 32'd0);
        chk("mid_rst_rob",   32'(bus.redirect_rob_idx), 32'd0);
        chk("mid_rst_fsq",   32'(bus.redirect_fsq_idx), 32'd0);
        chk("mid_rst_off",   32'(bus.redirect_fsq_off), 32'd0);
        chk("mid_rst_exc",   32'(bus.redirect_is_exc), 32'd0);
        tick();
        chk("post_rst_en",    32'(bus.redirect_en), 32'd0);
        chk("post_rst_stall", 32'(bus.flush_stall), 32'd0);
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/backend_redirect_arbiter.md
# backend_redirect_arbiter

Parametrised redirect arbiter for the out-of-order backend. Collects misprediction and memory-violation redirects from `SRC_NUM` execution sources, plus a ROB exception redirect, and selects the oldest by ROB index. It emits a single registered redirect pulse to the FSQ and ROB. A counter-driven flush window then holds the front end stalled and filters redirects the current flush has already squashed.

## Interface
- `SRC_NUM`, 4: number of execution redirect sources (branch ALUs plus LSU); must be at least 1.
- `ROB_W`, 6: ROB index width; every robIdx carries one extra MSB direction (wrap) bit, so it is ROB_W+1 bits wide.
- `FSQ_W`, 5: FSQ index width.
- `OFF_W`, 5: fetch-block offset width.
- `FLUSH_CYCLES`, 3: length of the stall window after each redirect; must be at least 1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `src_valid`  in  SRC_NUM  per-source redirect request.
- `src_rob_idx`  in  SRC_NUM×(ROB_W+1)  robIdx of the redirecting instruction.
- `src_fsq_idx`  in  SRC_NUM×FSQ_W  FSQ entry.
- `src_fsq_off`  in  SRC_NUM×OFF_W  offset within the fetch block.
- `exc_valid`  in  1  ROB-head exception redirect; always treated as oldest.
- `exc_rob_idx`, `exc_fsq_idx`, `exc_fsq_off`  in  ROB_W+1 / FSQ_W / OFF_W  exception info.
- `redirect_en`  out  1  one-cycle redirect pulse.
- `redirect_rob_idx`, `redirect_fsq_idx`, `redirect_fsq_off`  out  ROB_W+1 / FSQ_W / OFF_W  info for the redirect that won arbitration.
- `redirect_is_exc`  out  1  the winner came from `exc_valid`.
- `flush_stall`  out  1  front-end stall during the flush window.

## Operation
- Age rule: A is older than B when either of these holds:
  - the direction bits are equal and idx(A) < idx(B);
  - the direction bits differ and idx(A) > idx(B).
- Equal robIdx means "not older".
- Stage 0 (combinational) picks a candidate:
  - If `exc_valid` is set, the exception is the candidate.
  - Otherwise the candidate is the oldest valid source.
  - Ties go to the lowest source index.
- FSM states:
  - IDLE → FLUSH when any candidate exists. The candidate is registered, `redirect_en` is pulsed, and the counter is loaded with FLUSH_CYCLES−1.
  - FLUSH with the counter at 0 and no accepted candidate → IDLE.
  - FLUSH, otherwise: the counter decrements.
- Filtering in FLUSH: a source candidate is accepted only if it is strictly older than the registered robIdx. Equal or younger candidates are dropped silently, because they are already squashed.
  - `exc_valid` is always accepted.
  - Accepting a candidate re-registers it, re-pulses `redirect_en` and reloads the counter. The state stays FLUSH.
- `flush_stall` equals (state == FLUSH).
- Redirect info outputs hold the last winner and change only on acceptance.
- Counter width is clog2(FLUSH_CYCLES)+1 bits. It never underflows: at 0 the FSM leaves FLUSH.

## Timing
- Reset values: state IDLE, counter 0, `redirect_en` 0, `flush_stall` 0, `redirect_is_exc` 0, all index/offset outputs 0.
- Latency: a request accepted at cycle t produces `redirect_en`=1 at t+1, for exactly one cycle unless another candidate is accepted at t+1.
- Stall window: `flush_stall` is 1 from t+1 through t+FLUSH_CYCLES inclusive and 0 at t+FLUSH_CYCLES+1 when nothing else is accepted.
- Back-to-back accepted redirects give consecutive `redirect_en` pulses, each with its own info, and restart the window.
- A simultaneous exception and older source redirect: the exception wins.
- Wrap-around: comparison is by the direction bit, never by raw magnitude.
- `rst` asserted mid-flush: the next cycle shows IDLE with all outputs 0. Requests present in the reset cycle are discarded.
- No backpressure: the consumer takes `redirect_en` unconditionally.

## Test plan
- Single source: SRC_NUM=4, FLUSH_CYCLES=3, src_valid=4'b0100 with robIdx=0x05 at cycle 10.
  - Required: `redirect_en` only at cycle 11 with rob 0x05.
  - Required: `flush_stall` high for cycles 11–13, low at 14.
- Oldest selection with wrap: same cycle, src0 rob=0x45 and src2 rob=0x3E.
  - Required: winner src2 (0x3E, dir 0), since 0x45 has dir 1 and is younger.
- Filtering in FLUSH: after accepting rob 0x10, at t+1 src1 presents rob 0x12 and at t+2 src3 presents rob 0x0C.
  - Required: 0x12 is dropped with no pulse.
  - Required: 0x0C pulses at t+3 and the stall window extends to t+5.
- Exception priority: `exc_valid` with rob 0x20 alongside src0 rob 0x01.
  - Required: `redirect_is_exc`=1 and rob 0x20.
  - Also issue an exception during FLUSH with a younger index: it is still accepted.
- Tie: src1 and src3 both present rob 0x08 → winner src1's fsq_idx/off.
- Reset mid-flush: assert `rst` at the second cycle of FLUSH.
  - Required: the following cycle shows `flush_stall`=0, `redirect_en`=0, all info 0.
  - Required: a src_valid present during the reset cycle produces no pulse.
